// File: rtl/edge_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : edge_writer_if
// Brief    : valid/ready stream carrying row-major edge values into edge_writer
// Revision : 1.0
// ============================================================================
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

interface edge_writer_if #(
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) ();
  logic                   in_valid;
  logic [VALUE_WIDTH-1:0] in_value;
  logic                   in_ready;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

`default_nettype wire

// File: rtl/edge_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : edge_writer
// Brief    : streams an N x N adjacency matrix row-major into the shared
//            BlockRam write port; the bus is released (high-Z) when idle
// Revision : 1.0
// ============================================================================
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module edge_writer #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic [MADDR_WIDTH-1:0]   base_address,
  input  wire logic [INDEX_WIDTH-1:0]   number_of_nodes,
  input  wire logic                     start,
  edge_writer_if.slave                  stream,
  output wire       [MADDR_WIDTH-1:0]   mem_addr,
  output logic      [MDATA_WIDTH-1:0]   mem_write_data,
  output wire                           mem_write_enable,
  input  wire logic                     mem_write_ready,
  output logic                          busy,
  output logic                          done,
  output logic      [2*INDEX_WIDTH-1:0] write_count
);

  localparam int c_STRIDE = MADDR_WIDTH / 8;

  // Parameter sanity is checked at elaboration; no hardware is produced.
  if ((MAX_NODES >= (1 << INDEX_WIDTH)) || (MDATA_WIDTH < VALUE_WIDTH)) begin : g_param_check
    $error("edge_writer: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_WRITE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                   r_state;
  logic [MADDR_WIDTH-1:0]   r_addr;
  logic [INDEX_WIDTH-1:0]   r_n;
  logic [INDEX_WIDTH-1:0]   r_row;
  logic [INDEX_WIDTH-1:0]   r_col;
  logic [2*INDEX_WIDTH-1:0] r_count;
  logic [MDATA_WIDTH-1:0]   r_data;
  logic                     r_in_ready;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_we;
  logic                     r_own;

  logic [INDEX_WIDTH-1:0]   w_n_last;
  logic                     w_col_last;
  logic                     w_elem_last;

  assign w_n_last    = r_n - INDEX_WIDTH'(1);
  assign w_col_last  = (r_col == w_n_last);
  assign w_elem_last = w_col_last && (r_row == w_n_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_n        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_own      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr  <= base_address;
            r_n     <= number_of_nodes;
            r_row   <= '0;
            r_col   <= '0;
            r_count <= '0;
            if (number_of_nodes == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ACCEPT;
              r_done     <= 1'b0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
              r_own      <= 1'b1;
            end
          end
        end

        S_ACCEPT: begin
          if (stream.in_valid) begin
            r_data     <= MDATA_WIDTH'(stream.in_value);
            r_in_ready <= 1'b0;
            r_we       <= 1'b1;
            r_state    <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (mem_write_ready) begin
            r_we    <= 1'b0;
            r_state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // Address advances by a fixed stride instead of multiplying row*N+col.
          r_count <= r_count + (2*INDEX_WIDTH)'(1);
          r_addr  <= r_addr + MADDR_WIDTH'(c_STRIDE);
          if (w_col_last) begin
            r_col <= '0;
            r_row <= r_row + INDEX_WIDTH'(1);
          end else begin
            r_col <= r_col + INDEX_WIDTH'(1);
          end
          if (w_elem_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_own   <= 1'b0;
          end else begin
            r_state    <= S_ACCEPT;
            r_in_ready <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_we       <= 1'b0;
          r_own      <= 1'b0;
        end
      endcase
    end
  end

  assign stream.in_ready  = r_in_ready;
  assign mem_addr         = r_own ? r_addr : {MADDR_WIDTH{1'bz}};
  assign mem_write_enable = r_own ? r_we : 1'bz;
  assign mem_write_data   = r_data;
  assign busy             = r_busy;
  assign done             = r_done;
  assign write_count      = r_count;

endmodule

`default_nettype wire

// File: doc/edge_writer.md
Name: edge_writer

Overview:
- Loads an N x N adjacency matrix into BlockRam, row-major, from a valid/ready value stream.
- Uses the same memory layout and write handshake that EdgeCache reads back: address = base + (row*N + col)*S, where S = MADDR_WIDTH/8.
- Sits between the host/loader side and the shared BlockRam bus.
- Drives the write side of the bus only while loading; releases it (high-Z) otherwise.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES, maximum N supported.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, width of node indices and of N.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, width of one edge value.
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width; stride S = MADDR_WIDTH/8.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width (>= VALUE_WIDTH).

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- base_address  input  MADDR_WIDTH  matrix base address; sampled on accepted start.
- number_of_nodes  input  INDEX_WIDTH  N; sampled on accepted start.
- start  input  1  begin a load; accepted only in IDLE or DONE.
- in_valid  input  1  in_value holds the next edge value.
- in_value  input  VALUE_WIDTH  edge value, row-major order.
- in_ready  output  1  writer accepts in_value this cycle.
- mem_addr  output  MADDR_WIDTH  write address; high-Z when the bus is not owned.
- mem_write_data  output  MDATA_WIDTH  zero-extended in_value.
- mem_write_enable  output  1  write strobe; high-Z when the bus is not owned.
- mem_write_ready  input  1  BlockRam write complete.
- busy  output  1  load in progress.
- done  output  1  sticky; all N*N values written.
- write_count  output  2*INDEX_WIDTH  values written since the last start.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - in_ready=0, busy=0, done=0, write_count=0, mem_write_data=0.
  - mem_addr and mem_write_enable go to 'bz.
  - A reset asserted mid-write abandons the write immediately; it is not retried.
- States:
  - IDLE: bus released. An accepted start latches base_address into addr_reg and N into n_reg, clears row, col and write_count, clears done, and moves to ACCEPT. If N==0 it goes directly to DONE with done=1 the next cycle.
  - ACCEPT: in_ready=1 and busy=1. On in_valid&&in_ready at a posedge, latch zero-extended in_value into mem_write_data and move to WRITE. in_ready is 0 in every other state.
  - WRITE: mem_write_enable=1; mem_addr=addr_reg; data held stable. Stay while mem_write_ready===0. At the first posedge with mem_write_ready==1, move to RELEASE.
  - RELEASE: one cycle with mem_write_enable=0 and mem_addr still driven.
    - write_count increments; addr_reg increments by S (modulo 2^MADDR_WIDTH).
    - col increments; at col==n_reg-1, col resets to 0 and row increments.
    - If this was element (n_reg-1, n_reg-1), move to DONE; otherwise move to ACCEPT.
  - DONE: done=1, busy=0, bus released to 'bz. A new start behaves as it does in IDLE.
- Start while busy is ignored and has no effect on the current load.
- Minimum cost per element: 3 cycles (ACCEPT, WRITE, RELEASE), plus any extra BlockRam wait cycles.
- Inputs sampled at start are stable for the whole load; later input changes are ignored.
- Address arithmetic uses an incrementing register, not a multiplier. It must equal base + (row*N + col)*S, truncated to MADDR_WIDTH.
- N > MAX_NODES is undefined and is not checked.

Test Plan:
1. MADDR_WIDTH=32, S=4, base=0, N=8; stream values row*col with in_valid held high -> 64 writes at addresses 0,4,...,252, each with data row*col. Final count=64; done=1 and busy=0 exactly one cycle after the last RELEASE. Read back through EdgeCache for all (r,c) -> edge_value == r*c.
2. Hold mem_write_ready low for 5 cycles on element (2,3) -> addr=76 and data=6 stay stable and mem_write_enable stays 1 throughout. in_ready stays 0 until the following ACCEPT; no element is skipped or duplicated.
3. Drop in_valid for 4 cycles mid-row -> FSM waits in ACCEPT with mem_write_enable='bz absent? No: enable is 0 and mem_addr is held. No spurious write occurs; the sequence resumes correctly.
4. Change base_address to 87 and number_of_nodes to 105 after start; also pulse start during the load -> no effect; the load still covers exactly N=8 from base 0.
5. Assert reset=0 during WRITE of element 10 -> mem_addr and mem_write_enable go to 'bz asynchronously; count=0, done=0, busy=0. A new start with N=2, base=100 -> writes go to 100, 104, 108 and 112.
6. Start with N=0 -> done=1 on the next cycle, no memory writes, count=0. Start with N=1, base=2^32-4 -> a single write at 0xFFFFFFFC; the register increment wraps to 0 without error.
